// File: rtl/flash_xip_cache_pkg.sv
// flash_xip_cache_pkg: shared FSM encoding and APB widths for the XIP cache
package flash_xip_cache_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;
endpackage

// File: rtl/flash_xip_cache_array.sv
// flash_xip_cache_array: direct-mapped tag/data/valid store, combinational lookup, synchronous fill
module flash_xip_cache_array
    import flash_xip_cache_pkg::*;
#(
    parameter int entries = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-3:0] lookup_word,
    output logic              hit,
    output logic [DATA_W-1:0] lookup_data,
    input  logic              fill_en,
    input  logic [ADDR_W-3:0] fill_word,
    input  logic [DATA_W-1:0] fill_data
);
    localparam int IW = $clog2(entries);
    localparam int TW = ADDR_W - 2 - IW;
    logic [entries-1:0] valid_q, valid_d;
    logic [TW-1:0]      tag_q  [entries];
    logic [TW-1:0]      tag_d  [entries];
    logic [DATA_W-1:0]  data_q [entries];
    logic [DATA_W-1:0]  data_d [entries];
    logic [IW-1:0]      l_idx, f_idx;
    assign l_idx       = lookup_word[IW-1:0];
    assign f_idx       = fill_word[IW-1:0];
    assign hit         = valid_q[l_idx] && (tag_q[l_idx] == lookup_word[ADDR_W-3:IW]);
    assign lookup_data = data_q[l_idx];
    // Flush wins over a same-cycle fill so a straddling refill never survives.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[f_idx] = 1'b1;
            tag_d[f_idx]   = fill_word[ADDR_W-3:IW];
            data_d[f_idx]  = fill_data;
        end
        if (flush) valid_d = '0;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < entries; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/flash_xip_cache.sv
// flash_xip_cache: APB read cache for execute-in-place flash, forwarding misses and non-flash traffic
module flash_xip_cache
    import flash_xip_cache_pkg::*;
#(
    parameter logic [ADDR_W-1:0] flash_addr_start = 32'h3000_0000,
    parameter logic [ADDR_W-1:0] flash_addr_end   = 32'h3fff_ffff,
    parameter int                entries          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic [2:0]        in_pprot,
    input  logic              in_pwrite,
    input  logic [DATA_W-1:0] in_pwdata,
    input  logic [STRB_W-1:0] in_pstrb,
    output logic              in_pready,
    output logic [DATA_W-1:0] in_prdata,
    output logic              in_pslverr,
    output logic [ADDR_W-1:0] out_paddr,
    output logic              out_psel,
    output logic              out_penable,
    output logic [2:0]        out_pprot,
    output logic              out_pwrite,
    output logic [DATA_W-1:0] out_pwdata,
    output logic [STRB_W-1:0] out_pstrb,
    input  logic              out_pready,
    input  logic [DATA_W-1:0] out_prdata,
    input  logic              out_pslverr
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, in_prdata_q, in_prdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [2:0]        prot_q, prot_d;
    logic              write_q, write_d, xip_q, xip_d, nofill_q, nofill_d;
    logic              psel_q, psel_d, penable_q, penable_d;
    logic              in_pready_q, in_pready_d, in_pslverr_q, in_pslverr_d;
    logic              xip, hit, fill_en;
    logic [DATA_W-1:0] hit_data;
    assign xip = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
    flash_xip_cache_array #(.entries(entries)) u_array (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .lookup_word (in_paddr[ADDR_W-1:2]),
        .hit         (hit),
        .lookup_data (hit_data),
        .fill_en     (fill_en),
        .fill_word   (addr_q[ADDR_W-1:2]),
        .fill_data   (out_prdata)
    );
    assign out_paddr   = addr_q;
    assign out_psel    = psel_q;
    assign out_penable = penable_q;
    assign out_pprot   = prot_q;
    assign out_pwrite  = write_q;
    assign out_pwdata  = wdata_q;
    assign out_pstrb   = strb_q;
    assign in_pready   = in_pready_q;
    assign in_prdata   = in_prdata_q;
    assign in_pslverr  = in_pslverr_q;
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        prot_d       = prot_q;
        write_d      = write_q;
        xip_d        = xip_q;
        nofill_d     = nofill_q | flush;
        psel_d       = psel_q;
        penable_d    = penable_q;
        in_pready_d  = 1'b0;
        in_prdata_d  = in_prdata_q;
        in_pslverr_d = in_pslverr_q;
        fill_en      = 1'b0;
        case (state_q)
            IDLE: begin
                nofill_d = 1'b0;
                if (in_psel && in_penable) begin
                    addr_d  = in_paddr;
                    wdata_d = in_pwdata;
                    strb_d  = in_pstrb;
                    prot_d  = in_pprot;
                    write_d = in_pwrite;
                    xip_d   = xip;
                    if (xip && !in_pwrite && hit) begin
                        state_d      = RESP;
                        in_pready_d  = 1'b1;
                        in_prdata_d  = hit_data;
                        in_pslverr_d = 1'b0;
                    end else if (xip && in_pwrite) begin
                        state_d      = RESP;
                        in_pready_d  = 1'b1;
                        in_prdata_d  = '0;
                        in_pslverr_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: if (out_pready) begin
                state_d      = RESP;
                psel_d       = 1'b0;
                penable_d    = 1'b0;
                in_pready_d  = 1'b1;
                in_prdata_d  = out_prdata;
                in_pslverr_d = out_pslverr;
                fill_en      = xip_q && !write_q && !out_pslverr && !nofill_q && !flush;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            prot_q       <= '0;
            write_q      <= 1'b0;
            xip_q        <= 1'b0;
            nofill_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            in_pready_q  <= 1'b0;
            in_prdata_q  <= '0;
            in_pslverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            prot_q       <= prot_d;
            write_q      <= write_d;
            xip_q        <= xip_d;
            nofill_q     <= nofill_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            in_pready_q  <= in_pready_d;
            in_prdata_q  <= in_prdata_d;
            in_pslverr_q <= in_pslverr_d;
        end
    end
endmodule
